// File: rtl/fir_decim_out.sv
// fir_decim_out
// Downstream stage of the FIR filter. Accumulates M input samples per group
// (decimate-by-M, accumulate-and-dump), rounds half toward +inf, shifts right
// by SHIFT, saturates to OUT_W bits and queues each result in a DEPTH-entry
// FIFO that drains over a valid/ready handshake.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   s_valid  input sample strobe (no backpressure toward the FIR)
//   s_data   signed input sample, IN_W bits
//   m_valid  output FIFO non-empty
//   m_ready  consumer accepts m_data this cycle
//   m_data   signed output sample (registered FIFO head), OUT_W bits
//   sat      one-cycle pulse after a dump whose value was clipped
//   ovf      sticky: a result was dropped because the FIFO was full
//   sat_cnt  16-bit saturating count of clipped dumps
//            (present only when FIR_DECIM_SATCNT_EN is defined)
//
// Optional feature macro: FIR_DECIM_SATCNT_EN
module fir_decim_out #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int M     = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             sat,
  output logic             ovf
`ifdef FIR_DECIM_SATCNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int ACC_W = IN_W + $clog2(M);
  // One extra bit so adding the rounding constant can never wrap.
  localparam int RW    = ACC_W + 1;
  localparam int PH_W  = (M > 1) ? $clog2(M) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [RW-1:0]    RND      = (RW'(1) << SHIFT) >> 1;

  logic [PH_W-1:0]         phase;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [RW-1:0]    sum_ext;
  logic signed [RW-1:0]    sum_rnd;
  logic signed [RW-1:0]    r;
  logic [OUT_W-1:0]        clipped;
  logic                    clip;
  logic                    dump;
  logic                    full;
  logic                    pop;
  logic                    push;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;

  assign m_valid = (count != '0);

  // Datapath: running sum, rounding, shift and saturation of the dump value.
  // The value fits OUT_W bits only when all bits above the output sign bit
  // match that sign bit.
  always_comb begin
    s_ext   = ACC_W'($signed(s_data));
    sum     = acc + s_ext;
    sum_ext = RW'(sum);
    sum_rnd = sum_ext + $signed(RND);
    r       = sum_rnd >>> SHIFT;
    clip    = !((&r[RW-1:OUT_W-1]) || !(|r[RW-1:OUT_W-1]));
    if (clip) begin
      clipped = r[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      clipped = r[OUT_W-1:0];
    end
    dump    = s_valid && (phase == PH_LAST);
    full    = (count == CNT_FULL);
    pop     = m_valid && m_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push    = dump && (!full || pop);
    rd_next = rd_ptr + 1'b1;
  end

  // Group accumulator: only valid samples advance it; the final sample of a
  // group dumps and restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (s_valid) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + 1'b1;
      end
    end
  end

  // FIFO storage has no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= clipped;
    end
  end

  // FIFO control and registered head. m_data is reloaded whenever the head
  // changes: after a pop (next stored entry, or the value being pushed if the
  // FIFO is about to hold only that), or on a push into an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      m_data <= '0;
      sat    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      sat <= dump && clip;
      if (dump && full && !pop) begin
        ovf <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        if (count > CNT_W'(1)) begin
          m_data <= mem[rd_next];
        end else if (push) begin
          m_data <= clipped;
        end
      end else if ((count == '0) && push) begin
        m_data <= clipped;
      end
    end
  end

`ifdef FIR_DECIM_SATCNT_EN
  // Counts every clipped dump, including ones dropped on overflow; sticks at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (dump && clip && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out
// Self-checking bench for fir_decim_out with default parameters. A queue-based
// model predicts the FIFO contents, sat pulse and ovf flag; a negedge process
// compares the DUT against it every cycle outside reset. Directed sequences
// pin known values, then a randomized phase exercises stalls and overflow.
module tb_fir_decim_out;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int M     = 4;
  localparam int SHIFT = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic [IN_W-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             sat;
  logic             ovf;
`ifdef FIR_DECIM_SATCNT_EN
  logic [15:0]      sat_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  longint           acc_m      = 0;
  int               phase_m    = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic             exp_sat    = 1'b0;
  logic             exp_ovf    = 1'b0;
  int               exp_satcnt = 0;

  fir_decim_out #(
    .IN_W(IN_W), .OUT_W(OUT_W), .M(M), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .sat(sat),
    .ovf(ovf)
`ifdef FIR_DECIM_SATCNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input logic rdy);
    s_valid = v;
    s_data  = d;
    m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: group sums in plain integer arithmetic, FIFO as a
  // bounded queue.
  always @(posedge clk or posedge rst) begin
    longint           sum_v;
    longint           r_v;
    logic             was_full;
    logic             do_pop;
    logic             clipped_f;
    if (rst) begin
      acc_m      = 0;
      phase_m    = 0;
      exp_q.delete();
      exp_sat    = 1'b0;
      exp_ovf    = 1'b0;
      exp_satcnt = 0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      do_pop   = (exp_q.size() > 0) && m_ready;
      exp_sat  = 1'b0;
      if (do_pop) void'(exp_q.pop_front());
      if (s_valid) begin
        acc_m   += longint'($signed(s_data));
        phase_m++;
        if (phase_m == M) begin
          sum_v     = acc_m;
          acc_m     = 0;
          phase_m   = 0;
          r_v       = (sum_v + ((longint'(1) << SHIFT) >> 1)) >>> SHIFT;
          clipped_f = 1'b0;
          if (r_v > (longint'(1) << (OUT_W-1)) - 1) begin
            r_v = (longint'(1) << (OUT_W-1)) - 1;
            clipped_f = 1'b1;
          end else if (r_v < -(longint'(1) << (OUT_W-1))) begin
            r_v = -(longint'(1) << (OUT_W-1));
            clipped_f = 1'b1;
          end
          exp_sat = clipped_f;
          if (clipped_f && exp_satcnt < 65535) exp_satcnt++;
          if (!was_full || do_pop) exp_q.push_back(r_v[OUT_W-1:0]);
          else exp_ovf = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) checkOutput("m_data", {16'd0, m_data}, {16'd0, exp_q[0]});
      checkOutput("sat", {31'd0, sat}, {31'd0, exp_sat});
      checkOutput("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`ifdef FIR_DECIM_SATCNT_EN
      checkOutput("sat_cnt", {16'd0, sat_cnt}, exp_satcnt);
`endif
    end
  end

  initial begin
    int mode;
    int mag;
    logic v;
    logic rdy;
    logic [IN_W-1:0] d;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", {16'd0, m_data}, 32'd0);
    checkOutput("rst_sat", {31'd0, sat}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    // Basic group: 1+2+3+4 = 10, (10+2)>>>2 = 3
    applyStimulus(1'b1, 32'd1, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b1);
    applyStimulus(1'b1, 32'd3, 1'b1);
    checkOutput("basic_early", {31'd0, m_valid}, 32'd0);
    applyStimulus(1'b1, 32'd4, 1'b1);
    checkOutput("basic_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("basic_data", {16'd0, m_data}, 32'd3);
    checkOutput("basic_sat", {31'd0, sat}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);

    // Negative group: -20 -> (-18)>>>2 = -5
    repeat (4) applyStimulus(1'b1, 32'hFFFF_FFFB, 1'b1);
    checkOutput("neg_data", {16'd0, m_data}, 32'h0000_FFFB);
    applyStimulus(1'b0, 32'd0, 1'b1);

    // Saturation both ways
    repeat (4) applyStimulus(1'b1, 32'd40000, 1'b1);
    checkOutput("sat_pos_data", {16'd0, m_data}, 32'h0000_7FFF);
    checkOutput("sat_pos_pulse", {31'd0, sat}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("sat_pos_end", {31'd0, sat}, 32'd0);
    repeat (4) applyStimulus(1'b1, -32'sd40000, 1'b1);
    checkOutput("sat_neg_data", {16'd0, m_data}, 32'h0000_8000);
    checkOutput("sat_neg_pulse", {31'd0, sat}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1);
`ifdef FIR_DECIM_SATCNT_EN
    checkOutput("sat_cnt_two", {16'd0, sat_cnt}, 32'd2);
`endif

    // Overflow: five groups into a stalled four-entry FIFO
    for (int g = 1; g <= 5; g++) begin
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'(4 * g), 1'b0);
    end
    checkOutput("ovf_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("ovf_head", {16'd0, m_data}, 32'd4);
    checkOutput("ovf_flag", {31'd0, ovf}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("drain_data", {16'd0, m_data}, 32'(4 * (k + 1)));
      applyStimulus(1'b0, 32'd0, 1'b1);
    end
    checkOutput("drain_empty", {31'd0, m_valid}, 32'd0);
    checkOutput("drain_ovf", {31'd0, ovf}, 32'd1);

    // Gaps in s_valid do not change the result
    applyStimulus(1'b1, 32'd1, 1'b1);
    applyStimulus(1'b0, 32'd99, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b1);
    applyStimulus(1'b0, 32'd99, 1'b1);
    applyStimulus(1'b0, 32'd99, 1'b1);
    applyStimulus(1'b1, 32'd3, 1'b1);
    applyStimulus(1'b0, 32'd99, 1'b1);
    checkOutput("gap_early", {31'd0, m_valid}, 32'd0);
    applyStimulus(1'b1, 32'd4, 1'b1);
    checkOutput("gap_data", {16'd0, m_data}, 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b1);

    // Reset mid-group discards the partial sum and clears ovf
    applyStimulus(1'b1, 32'd7, 1'b1);
    applyStimulus(1'b1, 32'd7, 1'b1);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'd1, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b1);
    applyStimulus(1'b1, 32'd3, 1'b1);
    applyStimulus(1'b1, 32'd4, 1'b1);
    checkOutput("post_rst_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("post_rst_data", {16'd0, m_data}, 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("post_rst_empty", {31'd0, m_valid}, 32'd0);

    // Randomized traffic with varying consumer stall rates
    for (int e = 0; e < 15; e++) begin
      for (int c = 0; c < 200; c++) begin
        v    = ($urandom_range(0, 3) != 0);
        rdy  = ($urandom_range(0, 9) < (e % 5) * 2 + 1);
        mode = $urandom_range(0, 3);
        case (mode)
          0:       d = $urandom;
          1:       d = 32'(int'($urandom_range(0, 200)) - 100);
          default: begin
            mag = $urandom_range(30000, 50000);
            d   = $urandom_range(0, 1) ? 32'(-mag) : 32'(mag);
          end
        endcase
        applyStimulus(v, d, rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
